execute_stage: RTL
==================

# execute_stage

Execute stage of the 5-stage RV32I pipeline. It selects ALU operands using the forwarding selects from the hazard unit, computes the ALU result, and resolves branches and jumps. It registers the results into the EX/MEM pipeline register, whose `rdM`/`regWriteM` outputs feed back into the hazard unit's memory-stage comparison.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fwdAE`, `fwdBE` in 2: forwarding selects from hazard unit.
- `rd1E`, `rd2E` in XLEN: register-file read data, ID/EX.
- `immE`, `pcE`, `pcPlus4E` in XLEN: immediate, PC, PC+4.
- `resultW` in XLEN: writeback result, forwarding source 01.
- `aluCtrlE` in 4: ALU op (package encoding).
- `funct3E` in 3: branch condition.
- `aluSrcE` in 1: 1 selects `immE` as ALU operand B.
- `branchE`, `jumpE`, `jalrE` in 1: control-transfer type.
- `regWriteE`, `memWriteE` in 1: stage controls.
- `resultSrcE` in 2: writeback select, carried through.
- `rdE` in 5: destination register.
- `stallM` in 1: hold EX/MEM register.
- `flushM` in 1: load a bubble into EX/MEM.
- `pcSrcE` out 1: redirect fetch (combinational).
- `pcTargetE` out XLEN: redirect target (combinational).
- `aluResultM`, `writeDataM`, `pcPlus4M` out XLEN: registered.
- `rdM` out 5; `regWriteM`, `memWriteM` out 1; `resultSrcM` out 2: registered.
- `misalignM` out 1: registered; the taken target of that instruction had bits[1:0] ≠ 0.

## Operation
- Operand A selection by `fwdAE`:
  - 00 → `rd1E`
  - 01 → `resultW`
  - 10 → `aluResultM`, the stage's own register output
  - 11 → `rd1E`
- `fwdBE` selects operand B from `rd2E` the same way, giving `fwdB`.
- ALU operand B is `immE` when `aluSrcE` is set, else `fwdB`. `writeDataM` always captures `fwdB`.
- ALU ops: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010. Any other code yields 0.
- Arithmetic is XLEN-bit and wraps; overflow is ignored. Shift amount is B[4:0]. SLT/SLTU produce 0 or 1.
- Branch condition, by `funct3E`:
  - BEQ 000, BNE 001
  - BLT 100, BGE 101 (signed)
  - BLTU 110, BGEU 111
  - Other codes: not taken.
- `pcSrcE = jumpE | (branchE & cond)`.
- `pcTargetE`: when `jalrE`, it is `(fwdA + immE) & ~1`; otherwise `pcE + immE`.
- EX/MEM register, priority `rst` > `flushM` > `stallM` > load:
  - reset or flush: every registered output is 0.
  - stall: all registered outputs hold.
  - load: capture this cycle's values.
- `misalignM` loads `pcSrcE & (pcTargetE[1:0] != 0)`.
- The stage never itself drives `flushM`/`stallM`; the hazard unit owns them.

## Timing
- Latency: ID/EX inputs appear on the M outputs 1 cycle later.
- `pcSrcE`/`pcTargetE` are combinational in the same cycle, with no register.
- Forwarding from 10 uses the current `aluResultM`, which is the previous instruction's result. Back-to-back dependent ALU ops therefore execute with no bubble.
- Under stall, `aluResultM` is frozen. Any forward from 10 during the stall reads the held value.
- Simultaneous `stallM` and `flushM`: flush wins.
- Asynchronous reset mid-operation:
  - All registered outputs go to 0 immediately.
  - `pcSrcE` still follows inputs combinationally; upstream stages are responsible for gating.
- `rdM`=0 with `regWriteM`=1 is legal; writeback ignores x0.

## Structure
- Package `pipe_pkg` holds:
  - `alu_op_t` (4-bit enum above)
  - `fwd_sel_t` (2-bit: `FWD_RF`, `FWD_W`, `FWD_M`)
  - `br_funct3_t` constants
  - `exmem_t`: packed struct of all EX/MEM fields, so the register is one `exmem_t` flop.
- One sub-module, `alu`: combinational, operands A/B plus `alu_op_t`, output result. Branch comparison stays in `execute_stage`.

## Test plan
- Reset:
  - Stimulus: assert `rst` mid-stream.
  - Required: all M outputs 0 asynchronously, before the next edge.
- Forwarding:
  - Stimulus: `rd1E`=5, `aluResultM`=0x10, `resultW`=0x20, `aluCtrlE`=ADD, `immE`=1, `aluSrcE`=1.
  - Required: `fwdAE`=10 → `aluResultM` 0x11 next cycle; 01 → 0x21; 11 → 0x6.
- Store data:
  - Stimulus: `fwdBE`=01, `resultW`=0xDEAD, `aluSrcE`=1.
  - Required: `writeDataM`=0xDEAD.
- Branches:
  - Stimulus: BLT with A=0xFFFFFFFF, B=1.
  - Required: `pcSrcE`=1. BLTU with the same operands: 0.
  - Stimulus: `pcE`=0x100, `immE`=0x20.
  - Required: `pcTargetE`=0x120.
- JALR:
  - Stimulus: A=0x203, `immE`=0.
  - Required: `pcTargetE`=0x202, `misalignM`=1 next cycle.
- Stall/flush:
  - Stimulus: `stallM`=1 for 2 cycles with changing inputs.
  - Required: outputs hold.
  - Stimulus: `stallM`=`flushM`=1.
  - Required: all M outputs 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline: ALU opcodes, forwarding selects,
// branch funct3 codes and the EX/MEM pipeline register layout.
package pipe_pkg;

  // Datapath width the EX/MEM struct is laid out for.
  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  // Code 2'b11 is unused and falls back to the register-file operand.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef logic [2:0] br_funct3_t;
  localparam br_funct3_t F3_BEQ  = 3'b000;
  localparam br_funct3_t F3_BNE  = 3'b001;
  localparam br_funct3_t F3_BLT  = 3'b100;
  localparam br_funct3_t F3_BGE  = 3'b101;
  localparam br_funct3_t F3_BLTU = 3'b110;
  localparam br_funct3_t F3_BGEU = 3'b111;

  typedef struct packed {
    logic [XLEN_DEF-1:0] alu_result;
    logic [XLEN_DEF-1:0] write_data;
    logic [XLEN_DEF-1:0] pc_plus4;
    logic [4:0]          rd;
    logic                reg_write;
    logic                mem_write;
    logic [1:0]          result_src;
    logic                misalign;
  } exmem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU; unknown opcodes produce zero.
module alu
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Operation select; arithmetic wraps, compares return 0/1.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register. XLEN must match pipe_pkg::XLEN_DEF because the
// EX/MEM register is a single packed struct sized by the package.
module execute_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      fwdAE,
  input  logic [1:0]      fwdBE,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] immE,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] pcPlus4E,
  input  logic [XLEN-1:0] resultW,
  input  logic [3:0]      aluCtrlE,
  input  logic [2:0]      funct3E,
  input  logic            aluSrcE,
  input  logic            branchE,
  input  logic            jumpE,
  input  logic            jalrE,
  input  logic            regWriteE,
  input  logic            memWriteE,
  input  logic [1:0]      resultSrcE,
  input  logic [4:0]      rdE,
  input  logic            stallM,
  input  logic            flushM,
  output logic            pcSrcE,
  output logic [XLEN-1:0] pcTargetE,
  output logic [XLEN-1:0] aluResultM,
  output logic [XLEN-1:0] writeDataM,
  output logic [XLEN-1:0] pcPlus4M,
  output logic [4:0]      rdM,
  output logic            regWriteM,
  output logic            memWriteM,
  output logic [1:0]      resultSrcM,
  output logic            misalignM
);

  exmem_t exmem_q, exmem_d;

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res, jalr_sum;
  logic            br_cond;

  // Forwarding muxes; M-stage source is this stage's own registered result.
  always_comb begin
    case (fwd_sel_t'(fwdAE))
      FWD_W:   fwd_a = resultW;
      FWD_M:   fwd_a = aluResultM;
      default: fwd_a = rd1E;
    endcase
    case (fwd_sel_t'(fwdBE))
      FWD_W:   fwd_b = resultW;
      FWD_M:   fwd_b = aluResultM;
      default: fwd_b = rd2E;
    endcase
  end

  assign alu_b = aluSrcE ? immE : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a_i      (fwd_a),
    .b_i      (alu_b),
    .op_i     (alu_op_t'(aluCtrlE)),
    .result_o (alu_res)
  );

  // Branch comparison always uses the forwarded register operands.
  always_comb begin
    br_cond = 1'b0;
    case (funct3E)
      F3_BEQ:  br_cond = (fwd_a == fwd_b);
      F3_BNE:  br_cond = (fwd_a != fwd_b);
      F3_BLT:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: br_cond = (fwd_a < fwd_b);
      F3_BGEU: br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum  = fwd_a + immE;
  assign pcSrcE    = jumpE | (branchE & br_cond);
  assign pcTargetE = jalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (pcE + immE);

  // Next EX/MEM contents.
  always_comb begin
    exmem_d            = '0;
    exmem_d.alu_result = alu_res;
    exmem_d.write_data = fwd_b;
    exmem_d.pc_plus4   = pcPlus4E;
    exmem_d.rd         = rdE;
    exmem_d.reg_write  = regWriteE;
    exmem_d.mem_write  = memWriteE;
    exmem_d.result_src = resultSrcE;
    exmem_d.misalign   = pcSrcE & (pcTargetE[1:0] != 2'b00);
  end

  // EX/MEM register: flush beats stall, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          exmem_q <= '0;
    else if (flushM)  exmem_q <= '0;
    else if (!stallM) exmem_q <= exmem_d;
  end

  assign aluResultM = exmem_q.alu_result;
  assign writeDataM = exmem_q.write_data;
  assign pcPlus4M   = exmem_q.pc_plus4;
  assign rdM        = exmem_q.rd;
  assign regWriteM  = exmem_q.reg_write;
  assign memWriteM  = exmem_q.mem_write;
  assign resultSrcM = exmem_q.result_src;
  assign misalignM  = exmem_q.misalign;

endmodule
